// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular queue of fetched {pc, instr} entries; flush wins over push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  fetch_entry_t    entry_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic [CntW-1:0] count_o,
    output fetch_entry_t    head_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CntW'(push_i) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word fetches and queues responses
// for decode; redirects flush the queue and discard in-flight words.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] pc_target_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_q, drop_d;

    logic [CntW-1:0] fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;
    logic            push;
    logic            pop;
    logic            gnt_fire;
    logic            resp_fire;
    logic [31:0]     credit_used;

    assign instr_valid_o = (fifo_count != '0);
    assign pop           = instr_valid_o && instr_ready_i;

    // A head leaving this cycle frees its slot, which keeps single-cycle memory at full rate.
    assign credit_used = 32'(outstanding_q) + 32'(fifo_count) - 32'(pop);
    // Gated by rst_n so the request stays low while reset is held.
    assign imem_req_o  = rst_n && !redirect_i && (credit_used < DEPTH);
    assign imem_addr_o = fetch_pc_q;

    assign gnt_fire  = imem_req_o && imem_gnt_i;
    // Ignore stray responses with nothing outstanding (e.g. arriving just after reset).
    assign resp_fire = imem_rvalid_i && (outstanding_q != '0);

    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata_i};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CntW'(gnt_fire) - CntW'(resp_fire);
        drop_d        = drop_q;
        push          = 1'b0;
        if (redirect_i) begin
            fetch_pc_d = word_align(pc_target_i);
            resp_pc_d  = word_align(pc_target_i);
            drop_d     = outstanding_q - CntW'(resp_fire);
        end else begin
            if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (resp_fire) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CntW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    assign instr_o    = instr_valid_o ? fifo_head.instr : NOP_INSTR;
    assign pc_o       = instr_valid_o ? fifo_head.pc : 32'd0;
    assign pc_plus4_o = pc_o + 32'd4;

endmodule
